// File: rtl/round_ctrl_pkg.sv
// Shared types and sizes for the FPU rounder sequencing controller.
// No logic of its own: no latency applies.
// No flow control of its own.
package round_ctrl_pkg;

  localparam int FW_DEF = 57;  // significand width
  localparam int EW_DEF = 13;  // exponent width
  localparam int LZW    = 6;   // leading-zero count / normalize shift width

  // Operation sequence: accept -> flag sample -> three datapath stages -> hand-off
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLAGS = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    POST  = 3'd4,
    DONE  = 3'd5
  } round_st_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant; the previous winner loses a tie.
// Purely combinational, zero latency.
// en low forces no grant; the caller owns the history register.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt
);

  // One-hot grant: a lone request wins, a tie goes to the index that was not served last
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/round_ctrl.sv
// Arbitrates two rounding requesters and steps the normalize/round/post-normalize stages.
// Accept to result: 5 cycles on the full path, 2 cycles when the stages are bypassed.
// One op in flight; requests are held off until the result is taken by res_ready.
module round_ctrl
  import round_ctrl_pkg::*;
#(
  parameter int FW = FW_DEF,
  parameter int EW = EW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [2*FW-1:0] req_fr,
  input  logic [2*EW-1:0] req_er,
  input  logic [1:0]      req_db,
  output logic [FW-1:0]   rnd_fr,
  output logic [EW-1:0]   rnd_er,
  output logic            rnd_db,
  input  logic            tiny_i,
  input  logic            ovf1_i,
  input  logic [LZW-1:0]  lz_i,
  input  logic            ovf_trap_en,
  output logic            norm_en,
  output logic            round_en,
  output logic            post_en,
  output logic [LZW-1:0]  norm_sh,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            res_id,
  output logic            res_tiny,
  output logic            res_ovf,
  output logic            res_special
);

  round_st_e state;
  round_st_e nxt_state;
  logic      last_served;
  logic      accept;
  logic      acc_id;
  logic      op_zero;
  logic      bypass;
  logic      arb_en;

  // Grant only while idle and out of reset, so req_ready is low during the reset cycle
  assign arb_en = rst_n && (state == IDLE);

  rr_arb2 u_arb (
    .req  (req_valid),
    .last (last_served),
    .en   (arb_en),
    .gnt  (req_ready)
  );

  assign accept  = |(req_valid & req_ready);
  assign acc_id  = req_ready[1];
  assign op_zero = (rnd_fr == '0);
  // Zero operands and untrapped overflows skip the three datapath stages
  assign bypass  = op_zero | (ovf1_i & ~ovf_trap_en);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  // Next-state decode
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (accept) nxt_state = FLAGS;
      FLAGS:   nxt_state = bypass ? DONE : NORM;
      NORM:    nxt_state = ROUND;
      ROUND:   nxt_state = POST;
      POST:    nxt_state = DONE;
      DONE:    if (res_ready) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Moore strobes and result valid, each tied to exactly one state
  always_comb begin
    norm_en   = (state == NORM);
    round_en  = (state == ROUND);
    post_en   = (state == POST);
    res_valid = (state == DONE);
  end

  // Operand capture on accept, flag capture in FLAGS; everything else holds
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_served <= 1'b1;
      rnd_fr      <= '0;
      rnd_er      <= '0;
      rnd_db      <= 1'b0;
      norm_sh     <= '0;
      res_id      <= 1'b0;
      res_tiny    <= 1'b0;
      res_ovf     <= 1'b0;
      res_special <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        rnd_fr      <= acc_id ? req_fr[FW +: FW] : req_fr[0 +: FW];
        rnd_er      <= acc_id ? req_er[EW +: EW] : req_er[0 +: EW];
        rnd_db      <= acc_id ? req_db[1] : req_db[0];
        res_id      <= acc_id;
        last_served <= acc_id;
      end
      if (state == FLAGS) begin
        norm_sh     <= lz_i;
        res_special <= bypass;
        // A zero significand carries no tiny/overflow meaning
        res_tiny    <= op_zero ? 1'b0 : tiny_i;
        res_ovf     <= op_zero ? 1'b0 : ovf1_i;
      end
    end
  end

endmodule

// File: tb/tb_round_ctrl.sv
// Self-checking bench for round_ctrl: vector table, corner sequences, random traffic.
// Model tracks each op by its cycle offset from acceptance.
// Consumer backpressure is driven both deliberately and randomly.
module tb_round_ctrl;
  localparam int FW = 57;
  localparam int EW = 13;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*FW-1:0] req_fr;
  logic [2*EW-1:0] req_er;
  logic [1:0]      req_db;
  logic [FW-1:0]   rnd_fr;
  logic [EW-1:0]   rnd_er;
  logic            rnd_db;
  logic            tiny_i, ovf1_i, ovf_trap_en;
  logic [5:0]      lz_i;
  logic            norm_en, round_en, post_en;
  logic [5:0]      norm_sh;
  logic            res_valid, res_ready, res_id, res_tiny, res_ovf, res_special;

  round_ctrl #(.FW(FW), .EW(EW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_fr(req_fr), .req_er(req_er), .req_db(req_db),
    .rnd_fr(rnd_fr), .rnd_er(rnd_er), .rnd_db(rnd_db),
    .tiny_i(tiny_i), .ovf1_i(ovf1_i), .lz_i(lz_i), .ovf_trap_en(ovf_trap_en),
    .norm_en(norm_en), .round_en(round_en), .post_en(post_en), .norm_sh(norm_sh),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_tiny(res_tiny), .res_ovf(res_ovf), .res_special(res_special)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic          m_busy = 1'b0;
  logic          m_last = 1'b1;
  logic          m_after_rst = 1'b0;
  int            m_acc = 0;
  logic          m_id;
  logic [FW-1:0] m_fr;
  logic [EW-1:0] m_er;
  logic          m_db;
  logic          m_special, m_tiny, m_ovf;
  logic [5:0]    m_sh;

  // A lone request wins; on a tie the requester not served last wins
  function automatic logic [1:0] model_grant(input logic [1:0] v, input logic last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  task automatic model_check();
    logic [1:0] g;
    int d;
    int done_at;
    if (!rst_n) begin
      check("ready_in_reset", req_ready, 2'b00);
      m_busy = 1'b0; m_last = 1'b1; m_after_rst = 1'b1;
      return;
    end
    if (m_after_rst) begin
      check("rst_rnd_fr", rnd_fr, 0);
      check("rst_rnd_er_db", {rnd_er, rnd_db}, 0);
      check("rst_norm_sh", norm_sh, 0);
      check("rst_res_flags", {res_id, res_tiny, res_ovf, res_special}, 0);
      m_after_rst = 1'b0;
    end
    if (!m_busy) begin
      g = model_grant(req_valid, m_last);
      check("req_ready_idle", req_ready, g);
      check("strobes_idle", {norm_en, round_en, post_en}, 3'b000);
      check("res_valid_idle", res_valid, 1'b0);
      if (g != 2'b00) begin
        m_id   = g[1];
        m_fr   = req_fr[m_id*FW +: FW];
        m_er   = req_er[m_id*EW +: EW];
        m_db   = req_db[m_id];
        m_last = m_id;
        m_acc  = cyc;
        m_busy = 1'b1;
      end
    end else begin
      d = cyc - m_acc;
      check("req_ready_busy", req_ready, 2'b00);
      check("rnd_fr_hold", rnd_fr, m_fr);
      check("rnd_er_db_hold", {rnd_er, rnd_db}, {m_er, m_db});
      if (d == 1) begin
        m_special = (m_fr == 0) || (ovf1_i && !ovf_trap_en);
        m_tiny    = (m_fr == 0) ? 1'b0 : tiny_i;
        m_ovf     = (m_fr == 0) ? 1'b0 : ovf1_i;
        m_sh      = lz_i;
        check("strobes_flags", {norm_en, round_en, post_en}, 3'b000);
        check("res_valid_flags", res_valid, 1'b0);
      end else begin
        done_at = m_special ? 2 : 5;
        check("strobes", {norm_en, round_en, post_en},
              {!m_special && d == 2, !m_special && d == 3, !m_special && d == 4});
        check("res_valid", res_valid, d >= done_at);
        check("norm_sh", norm_sh, m_sh);
        if (d >= done_at) begin
          check("res_fields", {res_id, res_special, res_tiny, res_ovf},
                {m_id, m_special, m_tiny, m_ovf});
          if (res_ready) m_busy = 1'b0;
        end
      end
    end
  endtask

  // ---------------- observations of the DUT ----------------
  logic   acc_seen, done_seen;
  int     obs_acc, obs_done, obs_strobes;
  logic   obs_id, obs_special, obs_tiny, obs_ovf;
  logic [1:0] gnt_q[$];
  int     acc_q[$];

  task automatic clear_obs();
    acc_seen = 0; done_seen = 0; obs_acc = -100; obs_done = -1; obs_strobes = 0;
    obs_id = 0; obs_special = 0; obs_tiny = 0; obs_ovf = 0;
    gnt_q.delete(); acc_q.delete();
  endtask

  // One clock: check at the falling edge, then return just after the rising edge
  task automatic tick();
    @(negedge clk);
    model_check();
    if (rst_n && |(req_valid & req_ready)) begin
      if (!acc_seen) obs_acc = cyc;
      acc_seen = 1;
      gnt_q.push_back(req_ready);
      acc_q.push_back(cyc);
    end
    if (res_valid && !done_seen) begin
      done_seen = 1; obs_done = cyc;
      obs_id = res_id; obs_special = res_special; obs_tiny = res_tiny; obs_ovf = res_ovf;
    end
    obs_strobes += int'(norm_en) + int'(round_en) + int'(post_en);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [FW-1:0] fr, input logic [EW-1:0] er, input logic db);
    req_fr = {fr ^ 57'h1, fr};
    if (fr == 0) req_fr = '0;
    req_er = {er + 13'd1, er};
    req_db = {db, db};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [FW-1:0] rand_fr();
    logic [63:0] w;
    w = {$urandom, $urandom};
    if ($urandom_range(3) == 0) w = 0;
    return w[FW-1:0];
  endfunction

  typedef struct {
    logic [1:0]    valid;
    logic [FW-1:0] fr;
    logic          tiny, ovf, trap;
    logic [5:0]    lz;
    logic          e_id;
    int            e_lat;
    logic          e_special, e_tiny, e_ovf;
    int            e_strobes;
  } vec_t;

  vec_t vecs[6];
  logic [FW-1:0] bp_fr;

  initial begin
    rst_n = 0; req_valid = 0; req_fr = 0; req_er = 0; req_db = 0;
    tiny_i = 0; ovf1_i = 0; lz_i = 0; ovf_trap_en = 0; res_ready = 1;
    clear_obs();

    vecs[0] = '{2'b01, 57'h100_0000_0000_0000, 0, 0, 0, 6'd0, 0, 5, 0, 0, 0, 3};
    vecs[1] = '{2'b10, 57'h0,                  1, 1, 0, 6'd7, 1, 2, 1, 0, 0, 0};
    vecs[2] = '{2'b01, 57'h0F0_1234,           0, 1, 0, 6'd2, 0, 2, 1, 0, 1, 0};
    vecs[3] = '{2'b10, 57'h1AB_CDEF,           0, 1, 1, 6'd9, 1, 5, 0, 0, 1, 3};
    vecs[4] = '{2'b11, 57'h000_0000_0000_0001, 1, 0, 0, 6'd56, 0, 5, 0, 1, 0, 3};
    vecs[5] = '{2'b11, 57'h055_5555,           0, 0, 1, 6'd1, 1, 5, 0, 0, 0, 3};

    @(posedge clk); #1;
    tick();
    do_reset();

    // Vector table: one op each, consumer always ready
    for (int i = 0; i < 6; i++) begin
      clear_obs();
      set_ops(vecs[i].fr, 13'h0010 + 13'(i), 1'b1);
      tiny_i = vecs[i].tiny; ovf1_i = vecs[i].ovf; ovf_trap_en = vecs[i].trap;
      lz_i = vecs[i].lz; res_ready = 1; req_valid = vecs[i].valid;
      repeat (9) begin
        tick();
        if (acc_seen) req_valid = 2'b00;
      end
      check($sformatf("v%0d_latency", i), obs_done - obs_acc, vecs[i].e_lat);
      check($sformatf("v%0d_id", i), obs_id, vecs[i].e_id);
      check($sformatf("v%0d_special", i), obs_special, vecs[i].e_special);
      check($sformatf("v%0d_tiny_ovf", i), {obs_tiny, obs_ovf}, {vecs[i].e_tiny, vecs[i].e_ovf});
      check($sformatf("v%0d_strobes", i), obs_strobes, vecs[i].e_strobes);
    end

    // Tie from reset: grants alternate 0,1,0 six cycles apart
    do_reset();
    clear_obs();
    set_ops(57'h123_4567_89AB, 13'h0100, 1'b0);
    tiny_i = 0; ovf1_i = 0; ovf_trap_en = 0; lz_i = 0; res_ready = 1;
    req_valid = 2'b11;
    repeat (20) tick();
    req_valid = 2'b00;
    check("tie_count", gnt_q.size() >= 3, 1'b1);
    if (gnt_q.size() >= 3) begin
      check("tie_g0", gnt_q[0], 2'b01);
      check("tie_g1", gnt_q[1], 2'b10);
      check("tie_g2", gnt_q[2], 2'b01);
      check("tie_spacing", acc_q[1] - acc_q[0], 6);
    end
    repeat (8) tick();

    // Backpressure: result and operands hold while the consumer stalls
    clear_obs();
    bp_fr = 57'h0AA_BBCC_DDEE;
    set_ops(bp_fr, 13'h0321, 1'b1);
    tiny_i = 1; lz_i = 6'd3; ovf1_i = 0; ovf_trap_en = 0; res_ready = 0;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    repeat (4) tick();
    tiny_i = 0; lz_i = 6'd5; req_valid = 2'b11; set_ops(57'h777, 13'h0002, 1'b0);
    repeat (4) begin
      tick();
      check("bp_valid", res_valid, 1'b1);
      check("bp_tiny", res_tiny, 1'b1);
      check("bp_norm_sh", norm_sh, 6'd3);
      check("bp_rnd_fr", rnd_fr, bp_fr);
      check("bp_ready", req_ready, 2'b00);
    end
    res_ready = 1;
    tick();
    req_valid = 2'b00;
    repeat (2) tick();

    // Reset during ROUND drops the op; next tie goes to requester 0
    clear_obs();
    set_ops(57'h1F0_0000, 13'h0044, 1'b1);
    tiny_i = 0; ovf1_i = 0; lz_i = 6'd4; res_ready = 1;
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    check("mid_round_en", round_en, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_no_valid", res_valid, 1'b0);
    check("mid_strobes", {norm_en, round_en, post_en}, 3'b000);
    clear_obs();
    req_valid = 2'b11;
    tick();
    req_valid = 2'b00;
    check("mid_tie_gnt", gnt_q.size() > 0 ? gnt_q[0] : 2'b00, 2'b01);
    repeat (8) tick();

    // Random traffic against the model, with rare resets
    for (int n = 0; n < 500; n++) begin
      req_valid   = 2'($urandom_range(3));
      req_fr      = {rand_fr(), rand_fr()};
      req_er      = 26'($urandom);
      req_db      = 2'($urandom_range(3));
      tiny_i      = 1'($urandom_range(1));
      ovf1_i      = ($urandom_range(2) == 0);
      ovf_trap_en = 1'($urandom_range(1));
      lz_i        = 6'($urandom_range(63));
      res_ready   = ($urandom_range(9) < 7);
      rst_n       = ($urandom_range(199) != 0);
      tick();
    end
    rst_n = 1'b1; req_valid = 2'b00; res_ready = 1'b1;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
